// File: rtl/csr_pkg.sv
// csr_pkg: CSR addresses, mstatus field positions and shared types for the machine-mode CSR file.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam int MIE_BIT  = 3;
    localparam int MPIE_BIT = 7;
    localparam int MPP_LO   = 11;
    localparam int MPP_HI   = 12;

    localparam logic [31:0] MISA_VAL = 32'h4000_0100;

    typedef logic [63:0] counter_t;

    // Only MIE/MPIE are stored; MPP is hardwired to machine mode.
    function automatic logic [31:0] mstatus_pack(input logic mie, input logic mpie);
        logic [31:0] v;
        v = '0;
        v[MIE_BIT] = mie;
        v[MPIE_BIT] = mpie;
        v[MPP_HI:MPP_LO] = 2'b11;
        return v;
    endfunction

endpackage

// File: rtl/csr_file_if.sv
// csr_file_if: core-side CSR access port (strobe, write qualifier, address, data, illegal flag).
interface csr_file_if;
    logic        csr;
    logic        csr_wr_en;
    logic [11:0] csr_rd_addr;
    logic [31:0] csr_wr_data;
    logic [31:0] csr_rd_data;
    logic        csr_illegal;

    modport master (
        output csr, csr_wr_en, csr_rd_addr, csr_wr_data,
        input  csr_rd_data, csr_illegal
    );

    modport slave (
        input  csr, csr_wr_en, csr_rd_addr, csr_wr_data,
        output csr_rd_data, csr_illegal
    );
endinterface

// File: rtl/csr_file_counter64.sv
// csr_counter64: 64-bit counter with increment enable and independent low/high half loads.
module csr_counter64
    import csr_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        inc,
    input  logic        ld_lo,
    input  logic        ld_hi,
    input  logic [31:0] ld_val,
    output counter_t    cnt
);

    counter_t    cnt_q, cnt_d;
    logic [32:0] lo_sum;

    // A load of either half suppresses the carry into the high half for that cycle.
    always_comb begin
        lo_sum = {1'b0, cnt_q[31:0]} + {32'b0, inc};
        cnt_d[31:0] = ld_lo ? ld_val : lo_sum[31:0];
        cnt_d[63:32] = ld_hi ? ld_val : ld_lo ? cnt_q[63:32] : cnt_q[63:32] + {31'b0, lo_sum[32]};
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) cnt_q <= '0;
        else cnt_q <= cnt_d;

    assign cnt = cnt_q;

endmodule

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR file with combinational reads, next-edge writes,
// 64-bit cycle/instret counters and trap/mret bookkeeping.
module csr_file
    import csr_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] HART_ID   = 32'h0
) (
    input  logic             clk,
    input  logic             reset,
    csr_file_if.slave        bus,
    input  logic             instret,
    input  logic             trap_valid,
    input  logic [31:0]      trap_cause,
    input  logic [31:0]      trap_pc,
    input  logic             mret,
    output logic [31:0]      mtvec,
    output logic [31:0]      mepc,
    output logic [31:0]      mstatus
);

    logic        mie_q, mie_d, mpie_q, mpie_d;
    logic [31:0] mtvec_q, mtvec_d, mepc_q, mepc_d;
    logic [31:0] mscratch_q, mscratch_d, mcause_q, mcause_d;
    counter_t    cycle_cnt, instret_cnt;
    logic [31:0] rd_data;
    logic        impl, illegal, we, sys_we;
    logic [11:0] addr;
    logic [31:0] wd;

    assign addr = bus.csr_rd_addr;
    assign wd = bus.csr_wr_data;

    always_comb begin
        rd_data = '0;
        impl = 1'b1;
        case (addr)
            CSR_MSTATUS:                 rd_data = mstatus_pack(mie_q, mpie_q);
            CSR_MISA:                    rd_data = MISA_VAL;
            CSR_MTVEC:                   rd_data = mtvec_q;
            CSR_MSCRATCH:                rd_data = mscratch_q;
            CSR_MEPC:                    rd_data = mepc_q;
            CSR_MCAUSE:                  rd_data = mcause_q;
            CSR_MCYCLE, CSR_CYCLE:       rd_data = cycle_cnt[31:0];
            CSR_MCYCLEH, CSR_CYCLEH:     rd_data = cycle_cnt[63:32];
            CSR_MINSTRET, CSR_INSTRET:   rd_data = instret_cnt[31:0];
            CSR_MINSTRETH, CSR_INSTRETH: rd_data = instret_cnt[63:32];
            CSR_MHARTID:                 rd_data = HART_ID;
            default:                     impl = 1'b0;
        endcase
    end

    assign illegal = bus.csr && (!impl || (bus.csr_wr_en && addr[11:10] == 2'b11));
    assign we = bus.csr && bus.csr_wr_en && !illegal;
    // Trap and mret own mstatus/mepc/mcause; a concurrent software write to them is dropped.
    assign sys_we = we && !trap_valid && !mret;

    always_comb begin
        mtvec_d = (we && addr == CSR_MTVEC) ? {wd[31:2], 2'b00} : mtvec_q;
        mscratch_d = (we && addr == CSR_MSCRATCH) ? wd : mscratch_q;
        mepc_d = trap_valid ? {trap_pc[31:2], 2'b00} :
                 (sys_we && addr == CSR_MEPC) ? {wd[31:2], 2'b00} : mepc_q;
        mcause_d = trap_valid ? trap_cause : (sys_we && addr == CSR_MCAUSE) ? wd : mcause_q;
        mie_d = trap_valid ? 1'b0 : mret ? mpie_q : (sys_we && addr == CSR_MSTATUS) ? wd[MIE_BIT] : mie_q;
        mpie_d = trap_valid ? mie_q : mret ? 1'b1 : (sys_we && addr == CSR_MSTATUS) ? wd[MPIE_BIT] : mpie_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mie_q <= 1'b0;
            mpie_q <= 1'b0;
            mtvec_q <= {RESET_VEC[31:2], 2'b00};
            mepc_q <= '0;
            mscratch_q <= '0;
            mcause_q <= '0;
        end else begin
            mie_q <= mie_d;
            mpie_q <= mpie_d;
            mtvec_q <= mtvec_d;
            mepc_q <= mepc_d;
            mscratch_q <= mscratch_d;
            mcause_q <= mcause_d;
        end
    end

    csr_counter64 u_cycle (
        .clk    (clk),
        .reset  (reset),
        .inc    (1'b1),
        .ld_lo  (we && addr == CSR_MCYCLE),
        .ld_hi  (we && addr == CSR_MCYCLEH),
        .ld_val (wd),
        .cnt    (cycle_cnt)
    );

    csr_counter64 u_instret (
        .clk    (clk),
        .reset  (reset),
        .inc    (instret),
        .ld_lo  (we && addr == CSR_MINSTRET),
        .ld_hi  (we && addr == CSR_MINSTRETH),
        .ld_val (wd),
        .cnt    (instret_cnt)
    );

    assign bus.csr_rd_data = rd_data;
    assign bus.csr_illegal = illegal;
    assign mtvec = mtvec_q;
    assign mepc = mepc_q;
    assign mstatus = mstatus_pack(mie_q, mpie_q);

endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: directed plus random stimulus against a behavioural CSR model, checked by a queue-fed monitor.
module tb_csr_file;

    localparam logic [31:0] RV  = 32'h0000_0100;
    localparam logic [31:0] HID = 32'h0000_0005;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        instret = 1'b0, trap_valid = 1'b0, mret = 1'b0;
    logic [31:0] trap_cause = '0, trap_pc = '0;
    logic [31:0] mtvec, mepc, mstatus;

    csr_file_if bus ();

    csr_file #(.RESET_VEC(RV), .HART_ID(HID)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .instret    (instret),
        .trap_valid (trap_valid),
        .trap_cause (trap_cause),
        .trap_pc    (trap_pc),
        .mret       (mret),
        .mtvec      (mtvec),
        .mepc       (mepc),
        .mstatus    (mstatus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic        ill;
        logic [31:0] tv;
        logic [31:0] ep;
        logic [31:0] st;
    } exp_t;

    exp_t q[$];
    int vectors = 0;
    int miscompares = 0;

    bit          s_rn, s_c, s_we, s_ir, s_tv, s_mr;
    logic [11:0] s_a;
    logic [31:0] s_wd, s_tc, s_tp;

    bit          m_mie, m_mpie;
    logic [31:0] m_mtvec, m_mepc, m_mscratch, m_mcause;
    logic [63:0] m_cyc, m_ins;

    function automatic logic [31:0] m_status();
        return 32'h1800 | (m_mpie ? 32'h80 : 32'h0) | (m_mie ? 32'h8 : 32'h0);
    endfunction

    function automatic logic [32:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return {1'b1, m_status()};
            12'h301: return {1'b1, 32'h4000_0100};
            12'h305: return {1'b1, m_mtvec};
            12'h340: return {1'b1, m_mscratch};
            12'h341: return {1'b1, m_mepc};
            12'h342: return {1'b1, m_mcause};
            12'hB00, 12'hC00: return {1'b1, m_cyc[31:0]};
            12'hB80, 12'hC80: return {1'b1, m_cyc[63:32]};
            12'hB02, 12'hC02: return {1'b1, m_ins[31:0]};
            12'hB82, 12'hC82: return {1'b1, m_ins[63:32]};
            12'hF14: return {1'b1, HID};
            default: return 33'h0;
        endcase
    endfunction

    task automatic m_reset();
        m_mie = 0; m_mpie = 0;
        m_mtvec = RV & ~32'h3;
        m_mepc = '0; m_mscratch = '0; m_mcause = '0;
        m_cyc = '0; m_ins = '0;
    endtask

    task automatic idle();
        s_c = 0; s_we = 0; s_a = '0; s_wd = '0;
        s_ir = 0; s_tv = 0; s_mr = 0; s_tc = '0; s_tp = '0;
    endtask

    task automatic acc(input bit c, input bit w, input logic [11:0] a, input logic [31:0] d);
        s_c = c; s_we = w; s_a = a; s_wd = d;
    endtask

    // One clock of stimulus: drive, predict outputs from the model, then advance the model.
    task automatic tick(input bit use_k, input logic [31:0] k);
        logic [32:0] r;
        logic        ill;
        logic [31:0] lo;
        logic [63:0] cn, inn;
        exp_t        e;
        @(posedge clk);
        #1;
        reset = s_rn; bus.csr = s_c; bus.csr_wr_en = s_we; bus.csr_rd_addr = s_a;
        bus.csr_wr_data = s_wd; instret = s_ir; trap_valid = s_tv; trap_cause = s_tc;
        trap_pc = s_tp; mret = s_mr;
        if (!s_rn) m_reset();
        r = m_read(s_a);
        ill = s_c && (!r[32] || (s_we && s_a[11:10] == 2'b11));
        e.rd = use_k ? k : r[31:0];
        e.ill = ill; e.tv = m_mtvec; e.ep = m_mepc; e.st = m_status();
        q.push_back(e);
        if (s_rn) begin
            cn = m_cyc + 64'd1;
            inn = m_ins + 64'(s_ir);
            if (s_c && s_we && !ill) begin
                case (s_a)
                    12'hB00: cn = {m_cyc[63:32], s_wd};
                    12'hB80: begin lo = m_cyc[31:0] + 32'd1; cn = {s_wd, lo}; end
                    12'hB02: inn = {m_ins[63:32], s_wd};
                    12'hB82: begin lo = m_ins[31:0] + 32'(s_ir); inn = {s_wd, lo}; end
                    12'h305: m_mtvec = s_wd & ~32'h3;
                    12'h340: m_mscratch = s_wd;
                    12'h300: if (!s_tv && !s_mr) begin m_mie = s_wd[3]; m_mpie = s_wd[7]; end
                    12'h341: if (!s_tv && !s_mr) m_mepc = s_wd & ~32'h3;
                    12'h342: if (!s_tv && !s_mr) m_mcause = s_wd;
                    default: ;
                endcase
            end
            if (s_tv) begin
                m_mepc = s_tp & ~32'h3; m_mcause = s_tc; m_mpie = m_mie; m_mie = 0;
            end else if (s_mr) begin
                m_mie = m_mpie; m_mpie = 1;
            end
            m_cyc = cn; m_ins = inn;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("rd_data", bus.csr_rd_data, e.rd);
                chk("csr_illegal", {31'b0, bus.csr_illegal}, {31'b0, e.ill});
                chk("mtvec", mtvec, e.tv);
                chk("mepc", mepc, e.ep);
                chk("mstatus", mstatus, e.st);
            end
        end
    end

    logic [11:0] al [20] = '{12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342,
                             12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80,
                             12'hC02, 12'hC82, 12'hF14, 12'h7C0, 12'h344, 12'hF11,
                             12'h000, 12'h300};

    initial begin
        bus.csr = 0; bus.csr_wr_en = 0; bus.csr_rd_addr = '0; bus.csr_wr_data = '0;
        m_reset();
        idle();
        s_rn = 0;
        acc(1, 0, 12'h305, 0); tick(1, 32'h100);
        acc(1, 0, 12'h300, 0); tick(1, 32'h1800);
        acc(1, 0, 12'hF14, 0); tick(1, HID);
        acc(1, 0, 12'hB00, 0); tick(1, 0);
        acc(1, 0, 12'hC82, 0); tick(1, 0);
        s_rn = 1;
        acc(1, 1, 12'h340, 32'hDEAD_BEEF); tick(0, 0);
        acc(1, 0, 12'h340, 0); tick(1, 32'hDEAD_BEEF);
        acc(1, 1, 12'h305, 32'h123); tick(0, 0);
        acc(1, 0, 12'h305, 0); tick(1, 32'h120);
        acc(1, 1, 12'hB80, 0); tick(0, 0);
        acc(1, 1, 12'hB00, 32'hFFFF_FFFF); tick(0, 0);
        acc(0, 0, 12'h000, 0); tick(0, 0);
        acc(1, 0, 12'hC80, 0); tick(1, 1);
        acc(1, 0, 12'hC00, 0); tick(1, 1);
        acc(1, 1, 12'hC00, 5); tick(1, 2);
        acc(1, 0, 12'hC00, 0); tick(1, 3);
        acc(1, 1, 12'h300, 32'h8); tick(0, 0);
        acc(1, 1, 12'h341, 32'hFFFF_FFF0); s_tv = 1; s_tc = 32'h2; s_tp = 32'h203; tick(0, 0);
        idle(); acc(1, 0, 12'h341, 0); tick(1, 32'h200);
        acc(1, 0, 12'h342, 0); tick(1, 32'h2);
        acc(1, 0, 12'h300, 0); tick(1, 32'h1880);
        idle(); s_mr = 1; tick(0, 0);
        idle(); acc(1, 0, 12'h300, 0); tick(1, 32'h1888);
        idle(); s_ir = 1; tick(0, 0); tick(0, 0);
        acc(1, 1, 12'hB02, 32'h10); tick(0, 0);
        idle(); s_ir = 1; tick(0, 0); tick(0, 0);
        idle(); acc(1, 0, 12'hB02, 0); tick(1, 32'h12);
        acc(1, 0, 12'h7C0, 0); tick(1, 0);
        acc(0, 0, 12'h7C0, 0); tick(1, 0);
        for (int i = 0; i < 2000; i++) begin
            s_rn = !(i >= 1000 && i < 1002);
            s_c = ($urandom % 4) != 0;
            s_we = 1'($urandom % 2);
            s_a = al[$urandom % 20];
            s_wd = $urandom;
            s_ir = 1'($urandom % 2);
            s_tv = ($urandom % 10) == 0;
            s_mr = ($urandom % 10) == 0;
            s_tc = $urandom;
            s_tp = $urandom;
            tick(0, 0);
        end
        s_rn = 1;
        idle();
        @(negedge clk);
        @(posedge clk);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/csr_file.md
# csr_file

Machine-mode control-and-status register file answering the core's CSR access port: it decodes `csr_rd_addr`, returns `csr_rd_data` in the same cycle and commits `csr_wr_data` on the next clock edge. It also owns the 64-bit `mcycle`/`minstret` counters and the trap/`mret` bookkeeping of `mstatus`/`mepc`/`mcause`. It exports `mtvec`, `mepc` and `mstatus` to the PC/hazard control logic.

## Interface
Parameters:
- `RESET_VEC`, 32'h0000_0000: reset value of `mtvec` (bits [1:0] forced 0).
- `HART_ID`, 32'h0: value returned by `mhartid`.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-low reset.
- `csr`  in  1  CSR access strobe from the core.
- `csr_wr_en`  in  1  write qualifier (low for CSRRS/CSRRC with rs1 = x0); ignored when `csr` is low.
- `csr_rd_addr`  in  12  CSR address (instr[31:20]).
- `csr_wr_data`  in  32  final value to write, already computed by the core's ALU.
- `csr_rd_data`  out  32  current value of the addressed CSR; 0 when the address is unimplemented.
- `csr_illegal`  out  1  the access is illegal.
- `instret`  in  1  one-cycle pulse per retired instruction.
- `trap_valid`  in  1  trap taken this cycle.
- `trap_cause`  in  32  value to load into `mcause`.
- `trap_pc`  in  32  PC of the faulting instruction.
- `mret`  in  1  `mret` executed this cycle.
- `mtvec`, `mepc`, `mstatus`  out  32 each  registered copies of the CSRs.

## Operation
- Implemented CSRs:
  - `mstatus` 0x300: only MIE[3] and MPIE[7] are writable; MPP[12:11] reads 2'b11; all other bits read 0.
  - `misa` 0x301: reads 32'h4000_0100 (RV32I). Writes are ignored and are not illegal.
  - `mtvec` 0x305 and `mepc` 0x341: bits [1:0] forced 0.
  - `mscratch` 0x340 and `mcause` 0x342: full 32-bit.
  - `mcycle`/`mcycleh` 0xB00/0xB80 and `minstret`/`minstreth` 0xB02/0xB82: read/write halves of the 64-bit counters.
  - `cycle`/`cycleh` 0xC00/0xC80 and `instret`/`instreth` 0xC02/0xC82: read-only shadows of the counters.
  - `mhartid` 0xF14: read-only, returns `HART_ID`.
- `csr_illegal` is combinational and is only ever high while `csr` is high. It is high when:
  - the address is unimplemented, or
  - `csr_wr_en` is high and addr[11:10] == 2'b11 (read-only space).
- An illegal access writes nothing.
- `mcycle` increments by 1 every cycle. `minstret` increments by 1 on each `instret` pulse. Both wrap from 2^64−1 to 0; the carry out of the low half propagates into the high half in the same cycle.
- A CSR write to a counter half wins over the increment for that half only:
  - a write to `mcycle` loads the low half; the high half keeps its value with no carry that cycle.
  - a write to `mcycleh` loads the high half; the low half still increments, and any carry out of it is discarded that cycle.
  - `minstret`/`minstreth` follow the same rules.
- Trap (`trap_valid`), all in one edge:
  - `mepc` ← `trap_pc` & ~3
  - `mcause` ← `trap_cause`
  - MPIE ← MIE
  - MIE ← 0
- `mret`: MIE ← MPIE, MPIE ← 1.
- Priority in the same cycle:
  - `trap_valid` beats `mret`.
  - Both beat any CSR write to `mstatus`/`mepc`/`mcause`. The losing write is dropped and does not raise `csr_illegal`.
  - A CSR write to any other CSR still commits.

## Timing
- Read path is combinational from `csr_rd_addr` to `csr_rd_data`, with zero-cycle latency; the value returned is the pre-write value.
- Writes are visible on `csr_rd_data` and the exported ports starting the cycle after the strobe.
- Counter reads show the pre-increment value of the current cycle.
- Reset asserted at any time, including mid-access, asynchronously forces:
  - all CSRs to 0,
  - MPP to 2'b11,
  - `mtvec` to `RESET_VEC`.
- Counters resume at 0 on the first edge after reset deasserts. Reset never produces a partial write.

## Structure
- Package `csr_pkg`: 12-bit address localparams, `mstatus` bit positions (MIE, MPIE, MPP), `MISA_VAL`, and a typedef for the 64-bit counter.
- Sub-module `csr_counter64`: a 64-bit counter with an increment enable plus independent low/high load ports, carry handled as above. It is instantiated twice (cycle, instret).
- Everything else (decode, write mux, trap logic) lives in `csr_file`.

## Test plan
- Reset with `RESET_VEC` = 32'h100 → read 0x305 gives 32'h100; 0x300 gives 32'h1800; 0xF14 gives `HART_ID`; all counters read 0 after reset.
- Write 32'hDEAD_BEEF to 0x340 → `csr_rd_data` reads 32'hDEAD_BEEF the next cycle. Write 32'h123 to 0x305 → reads 32'h120.
- Load `mcycle` = 32'hFFFF_FFFF and `mcycleh` = 0 → two cycles later `cycleh` reads 1 and `cycle` reads 1. A write with `csr_wr_en` to 0xC00 → `csr_illegal` = 1 and the counter keeps counting.
- MIE = 1, then `trap_valid` with `trap_pc` = 32'h203 and `trap_cause` = 32'h2 in the same cycle as a CSR write to 0x341 → `mepc` = 32'h200, `mcause` = 2, `mstatus` = 32'h1880. A following `mret` → `mstatus` = 32'h1888.
- `instret` pulsed 5 times, interleaved with a write of 32'h10 to 0xB02 on the 3rd pulse → `minstret` reads 32'h12 at the end.
- Read of unimplemented 0x7C0 → `csr_rd_data` = 0 and `csr_illegal` = 1. With `csr` low → `csr_illegal` = 0.
